// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one block-memory port between
// an I-cache requester (port 0) and a D-cache requester (port 1). One
// transaction is in flight at a time. Grant is held from request capture until
// the memory handshake completes, plus one DONE cycle.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a BUSY watchdog. The
// watchdog ends a stalled transaction after TIMEOUT_CYCLES cycles and pulses
// arb_timeout_err.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_dataout,
  input  logic              p0_req_rw,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  output logic [DATA_W-1:0] p0_req_datain,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_dataout,
  input  logic              p1_req_rw,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  output logic [DATA_W-1:0] p1_req_datain,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_dataout,
  output logic              mem_req_rw,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic [DATA_W-1:0] mem_req_datain,
  output logic [1:0]        arb_grant,
  output logic              arb_timeout_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // index of the last served port
  logic              owner_q, owner_d;            // index of the current owner
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_dataout_q, mem_dataout_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_valid_q, mem_valid_d;
  logic [1:0]        grant_q, grant_d;
  logic              p0_ready_q, p0_ready_d;
  logic              p1_ready_q, p1_ready_d;
  logic [DATA_W-1:0] p0_datain_q, p0_datain_d;
  logic [DATA_W-1:0] p1_datain_q, p1_datain_d;
  logic              winner;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  assign arb_timeout_err = timeout_err_q;
`else
  assign arb_timeout_err = 1'b0;
`endif

  // A lone requester wins; on a tie the port that was not served last wins.
  assign winner = (p0_req_valid && p1_req_valid) ? ~last_grant_q : p1_req_valid;

  // State register with synchronous reset; an in-flight transaction is dropped.
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge value of its peers; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_dataout_q <= '0;
      mem_rw_q      <= 1'b0;
      mem_valid_q   <= 1'b0;
      grant_q       <= 2'b00;
      p0_ready_q    <= 1'b0;
      p1_ready_q    <= 1'b0;
      p0_datain_q   <= '0;
      p1_datain_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      timeout_cnt_q <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      mem_addr_q    <= mem_addr_d;
      mem_dataout_q <= mem_dataout_d;
      mem_rw_q      <= mem_rw_d;
      mem_valid_q   <= mem_valid_d;
      grant_q       <= grant_d;
      p0_ready_q    <= p0_ready_d;
      p1_ready_q    <= p1_ready_d;
      p0_datain_q   <= p0_datain_d;
      p1_datain_q   <= p1_datain_d;
`ifdef MEM_ARB_TIMEOUT_EN
      timeout_cnt_q <= timeout_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // Next-state logic: capture in IDLE, wait for memory in BUSY, one-cycle pulse in DONE.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an unassigned path would infer a latch.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    mem_addr_d    = mem_addr_q;
    mem_dataout_d = mem_dataout_q;
    mem_rw_d      = mem_rw_q;
    mem_valid_d   = mem_valid_q;
    grant_d       = grant_q;
    p0_ready_d    = 1'b0;
    p1_ready_d    = 1'b0;
    p0_datain_d   = p0_datain_q;
    p1_datain_d   = p1_datain_q;
`ifdef MEM_ARB_TIMEOUT_EN
    timeout_cnt_d = timeout_cnt_q;
    timeout_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (p0_req_valid || p1_req_valid) begin
          owner_d       = winner;
          mem_addr_d    = winner ? p1_req_addr    : p0_req_addr;
          mem_dataout_d = winner ? p1_req_dataout : p0_req_dataout;
          mem_rw_d      = winner ? p1_req_rw      : p0_req_rw;
          mem_valid_d   = 1'b1;
          grant_d       = winner ? 2'b10 : 2'b01;
          state_d       = ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          timeout_cnt_d = '0;
`endif
        end
      end

      ST_BUSY: begin
        if (mem_req_ready) begin
          mem_valid_d  = 1'b0;
          last_grant_d = owner_q;
          state_d      = ST_DONE;
          if (owner_q) begin
            p1_ready_d = 1'b1;
            if (!mem_rw_q) p1_datain_d = mem_req_datain;
          end else begin
            p0_ready_d = 1'b1;
            if (!mem_rw_q) p0_datain_d = mem_req_datain;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Memory never answered: complete to the owner with zero data.
          mem_valid_d   = 1'b0;
          last_grant_d  = owner_q;
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
          if (owner_q) begin
            p1_ready_d  = 1'b1;
            p1_datain_d = '0;
          end else begin
            p0_ready_d  = 1'b1;
            p0_datain_d = '0;
          end
        end else begin
          timeout_cnt_d = timeout_cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req_addr    = mem_addr_q;
  assign mem_req_dataout = mem_dataout_q;
  assign mem_req_rw      = mem_rw_q;
  assign mem_req_valid   = mem_valid_q;
  assign arb_grant       = grant_q;
  assign p0_req_ready    = p0_ready_q;
  assign p1_req_ready    = p1_ready_q;
  assign p0_req_datain   = p0_datain_q;
  assign p1_req_datain   = p1_datain_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized requesters and memory around mem_port_arbiter.
// Transactions are predicted on a timeline. A port may be granted once it is
// pending and the arbiter has been free since the edge two cycles after the
// last completion. The memory chooses its latency when a grant is predicted,
// which fixes the cycle the response must appear. A negedge monitor compares
// the DUT against the queued predictions every cycle.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int TO_CYC = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef struct {
    int    start_cyc;
    int    end_cyc;
    int    port;
    addr_t addr;
    word_t data;
    logic  rw;
  } mem_exp_t;
  typedef struct {
    int    start_cyc;
    int    rsp_cyc;
    int    port;
    word_t data;
    logic  err;
  } rsp_exp_t;

  logic        clk;
  logic        rst;
  addr_t       p0_req_addr, p1_req_addr, mem_req_addr;
  word_t       p0_req_dataout, p1_req_dataout, mem_req_dataout;
  logic        p0_req_rw, p1_req_rw, mem_req_rw;
  logic        p0_req_valid, p1_req_valid, mem_req_valid;
  logic        p0_req_ready, p1_req_ready, mem_req_ready;
  word_t       p0_req_datain, p1_req_datain, mem_req_datain;
  logic [1:0]  arb_grant;
  logic        arb_timeout_err;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_req_addr(p0_req_addr), .p0_req_dataout(p0_req_dataout), .p0_req_rw(p0_req_rw),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_datain(p0_req_datain),
    .p1_req_addr(p1_req_addr), .p1_req_dataout(p1_req_dataout), .p1_req_rw(p1_req_rw),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_datain(p1_req_datain),
    .mem_req_addr(mem_req_addr), .mem_req_dataout(mem_req_dataout), .mem_req_rw(mem_req_rw),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_datain(mem_req_datain),
    .arb_grant(arb_grant), .arb_timeout_err(arb_timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  mem_exp_t mq[$];
  rsp_exp_t rq[$];
  int       n_checks = 0;
  int       n_fail = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic word_t rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus and reference model ----------------
  bit    pend[2];
  addr_t r_addr[2];
  word_t r_data[2];
  logic  r_rw[2];
  word_t drv_last[2];
  int    last, owner, t_start, t_done, free_edge, rst_left;
  bit    active, never;
  word_t rdata;
  int    iss_pct[2];
  int    wd_pct, dmax, spur_pct, never_pct, mid_pct;

  task automatic drive_port(input int p, input bit owned);
    logic  v;
    addr_t a;
    word_t d;
    logic  w;
    if (!owned && pend[p]) begin
      v = 1'b1; a = r_addr[p]; d = r_data[p]; w = r_rw[p];
    end else begin
      // An owned port's fields are scrambled: the arbiter must use its copy.
      v = owned; a = $urandom(); d = rand_word(); w = 1'($urandom_range(0, 1));
    end
    if (p == 0) begin
      p0_req_valid = v; p0_req_addr = a; p0_req_dataout = d; p0_req_rw = w;
    end else begin
      p1_req_valid = v; p1_req_addr = a; p1_req_dataout = d; p1_req_rw = w;
    end
  endtask

  task automatic step();
    int e;
    int w;
    @(posedge clk);
    #1;
    e = cyc;
    if (rst_left == 0 && active && e >= t_start && e + 1 < t_done &&
        int'($urandom_range(0, 99)) < mid_pct)
      rst_left = 2;
    if (rst_left > 0) begin
      rst_left--;
      rst = 1'b1;
      active = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0; last = 1;
      drv_last[0] = '0; drv_last[1] = '0; free_edge = 0;
      drive_port(0, 1'b0);
      drive_port(1, 1'b0);
      mem_req_ready = 1'b0;
      return;
    end
    rst = 1'b0;
    if (active && e == t_done) begin
      active = 1'b0;
      pend[owner] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (!(active && owner == p)) begin
        if (pend[p]) begin
          if (int'($urandom_range(0, 99)) < wd_pct) pend[p] = 1'b0;
        end else if (int'($urandom_range(0, 99)) < iss_pct[p]) begin
          pend[p] = 1'b1; r_addr[p] = $urandom(); r_data[p] = rand_word();
          r_rw[p] = 1'($urandom_range(0, 1));
        end
      end
    end
    drive_port(0, active && owner == 0);
    drive_port(1, active && owner == 1);
    if (!active && e + 1 >= free_edge && (pend[0] || pend[1])) begin
      w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
      never = TO_EN && int'($urandom_range(0, 99)) < never_pct;
      t_start = e + 1;
      if (never) begin
        t_done = t_start + TO_CYC; rdata = '0; drv_last[w] = '0;
      end else begin
        t_done = t_start + 1 + int'($urandom_range(0, dmax));
        rdata = rand_word();
        if (!r_rw[w]) drv_last[w] = rdata;
      end
      mq.push_back('{t_start, t_done, w, r_addr[w], r_data[w], r_rw[w]});
      rq.push_back('{t_start, t_done, w, drv_last[w], logic'(never)});
      last = w; owner = w; active = 1'b1; free_edge = t_done + 2;
    end
    mem_req_ready  = 1'b0;
    mem_req_datain = rand_word();
    if (active && e + 1 > t_start && e + 1 <= t_done) begin
      if (!never && e + 1 == t_done) begin
        mem_req_ready = 1'b1; mem_req_datain = rdata;
      end
    end else if (int'($urandom_range(0, 99)) < spur_pct) begin
      mem_req_ready = 1'b1;  // stray pulse outside BUSY must be ignored
    end
  endtask

  initial begin : driver
    rst = 1'b1;
    p0_req_valid = 1'b0; p0_req_addr = '0; p0_req_dataout = '0; p0_req_rw = 1'b0;
    p1_req_valid = 1'b0; p1_req_addr = '0; p1_req_dataout = '0; p1_req_rw = 1'b0;
    mem_req_ready = 1'b0; mem_req_datain = '0;
    pend[0] = 1'b0; pend[1] = 1'b0; drv_last[0] = '0; drv_last[1] = '0;
    last = 1; owner = 0; t_start = 0; t_done = 0; free_edge = 0;
    active = 1'b0; never = 1'b0; rdata = '0; rst_left = 3;
    for (int it = 0; it < 2600; it++) begin
      if (it < 200) begin         // lone port 0, immediate re-requests
        iss_pct[0] = 100; iss_pct[1] = 0; wd_pct = 0; dmax = 4;
        spur_pct = 20; never_pct = 0; mid_pct = 0;
      end else if (it < 400) begin
        iss_pct[0] = 0; iss_pct[1] = 50; wd_pct = 0; dmax = 4;
        spur_pct = 20; never_pct = 0; mid_pct = 0;
      end else if (it < 1000) begin  // full contention, occasional reset
        iss_pct[0] = 100; iss_pct[1] = 100; wd_pct = 0; dmax = 3;
        spur_pct = 10; never_pct = 0; mid_pct = 2;
      end else begin              // mixed traffic with withdrawals and stalls
        iss_pct[0] = 30; iss_pct[1] = 30; wd_pct = 15; dmax = 7;
        spur_pct = 25; never_pct = 10; mid_pct = 1;
      end
      step();
    end
    iss_pct[0] = 0; iss_pct[1] = 0; wd_pct = 0; spur_pct = 0; mid_pct = 0;
    for (int it = 0; it < 200; it++) begin
      step();
      if (!active && mq.size() == 0 && rq.size() == 0) break;
    end
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- monitor / scoreboard ----------------
  word_t mon_last[2];

  initial begin : monitor
    logic [1:0] exp_g;
    logic [1:0] exp_r;
    logic       exp_v;
    logic       exp_err;
    mon_last[0] = '0;
    mon_last[1] = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        // Drop predictions from before this reset; later grants start after cyc.
        while (mq.size() > 0 && mq[0].start_cyc < cyc) mq.delete(0);
        while (rq.size() > 0 && rq[0].start_cyc < cyc) rq.delete(0);
        mon_last[0] = '0;
        mon_last[1] = '0;
        check("rst_mem_addr", word_t'(mem_req_addr), '0);
        check("rst_mem_dataout", mem_req_dataout, '0);
        check("rst_mem_rw", word_t'(mem_req_rw), '0);
      end
      exp_v = 1'b0;
      exp_g = 2'b00;
      if (mq.size() > 0 && cyc >= mq[0].start_cyc && cyc <= mq[0].end_cyc) begin
        exp_g = (mq[0].port == 0) ? 2'b01 : 2'b10;
        if (cyc < mq[0].end_cyc) begin
          exp_v = 1'b1;
          check("mem_addr", word_t'(mem_req_addr), word_t'(mq[0].addr));
          check("mem_dataout", mem_req_dataout, mq[0].data);
          check("mem_rw", word_t'(mem_req_rw), word_t'(mq[0].rw));
        end
      end
      check("mem_valid", word_t'(mem_req_valid), word_t'(exp_v));
      check("arb_grant", word_t'(arb_grant), word_t'(exp_g));
      exp_r = 2'b00;
      exp_err = 1'b0;
      if (rq.size() > 0 && rq[0].rsp_cyc == cyc) begin
        exp_r[rq[0].port] = 1'b1;
        exp_err = rq[0].err;
        mon_last[rq[0].port] = rq[0].data;
        rq.delete(0);
      end
      check("p0_ready", word_t'(p0_req_ready), word_t'(exp_r[0]));
      check("p1_ready", word_t'(p1_req_ready), word_t'(exp_r[1]));
      check("timeout_err", word_t'(arb_timeout_err), word_t'(exp_err));
      check("p0_datain", p0_req_datain, mon_last[0]);
      check("p1_datain", p1_req_datain, mon_last[1]);
      if (mq.size() > 0 && cyc == mq[0].end_cyc) mq.delete(0);
    end
  end

endmodule
